// File: rtl/imem_boot_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot/fetch sequencer.
package imem_ctrl_pkg;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] SENTINEL_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_OVF   = 2'b01,
    FLT_MISAL = 2'b10,
    FLT_RANGE = 2'b11
  } fault_t;

endpackage

// File: rtl/imem_boot_fetch_ctrl_if.sv
// Load stream, imem port and core fetch signals of the boot/fetch sequencer.
interface imem_boot_fetch_ctrl_if;
  logic        boot_start;
  logic        run_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  fault;

  modport master (
    input  boot_start, run_start, ld_valid, ld_data, ld_last, imem_rdata,
           stall, redirect, redirect_pc,
    output ld_ready, imem_we, imem_waddr, imem_wdata, imem_raddr,
           pc, instr, instr_valid, halted, fault
  );

  modport slave (
    output boot_start, run_start, ld_valid, ld_data, ld_last, imem_rdata,
           stall, redirect, redirect_pc,
    input  ld_ready, imem_we, imem_waddr, imem_wdata, imem_raddr,
           pc, instr, instr_valid, halted, fault
  );
endinterface

// File: rtl/imem_boot_fetch_ctrl_pc_gen.sv
// Fetch PC register with hold/+4/redirect selection and alignment/range checks.
module imem_pc_gen
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_init,
  input  logic        step_en,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        misal,
  output logic        range_err
);

  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * WORD_BYTES);

  logic [31:0] pc_q, pc_d, next_pc;

  // Checks are unqualified by state; the FSM decides whether they matter.
  always_comb begin
    next_pc   = redirect ? redirect_pc : pc_q + 32'(WORD_BYTES);
    misal     = ~stall & redirect & (redirect_pc[1:0] != 2'b00);
    range_err = ~stall & ~misal & (next_pc >= LIMIT);
    pc_d      = pc_q;
    if (pc_init) begin
      pc_d = RESET_PC;
    end else if (step_en & ~stall & ~misal & ~range_err) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/imem_boot_fetch_ctrl.sv
// Boot loader / fetch sequencer for the byte-organised imem of the single-cycle core.
// state | meaning
// IDLE  | after reset, waiting for boot_start or run_start
// LOAD  | accepting image words, writing imem little-endian
// RUN   | fetching from imem at pc
// HALT  | sentinel fetched or fault raised; waiting for a restart
module imem_boot_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [31:0] SENTINEL    = SENTINEL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_boot_fetch_ctrl_if.master bus
);

  state_t      state_q, state_d;
  fault_t      fault_q, fault_d;
  logic [31:0] wr_ptr_q, wr_ptr_d;

  logic        pc_init, step_en, misal, range_err, sentinel;
  logic        ld_ready, imem_we, instr_valid;
  logic [31:0] pc;

  imem_pc_gen #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .RESET_PC    (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_init     (pc_init),
    .step_en     (step_en),
    .stall       (bus.stall),
    .redirect    (bus.redirect),
    .redirect_pc (bus.redirect_pc),
    .pc          (pc),
    .misal       (misal),
    .range_err   (range_err)
  );

  assign sentinel = (bus.imem_rdata == SENTINEL);

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    wr_ptr_d    = wr_ptr_q;
    pc_init     = 1'b0;
    step_en     = 1'b0;
    ld_ready    = 1'b0;
    imem_we     = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (bus.boot_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          fault_d  = FLT_NONE;
        end else if (bus.run_start) begin
          state_d = RUN;
          pc_init = 1'b1;
          fault_d = FLT_NONE;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (bus.ld_valid) begin
          imem_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + 32'd1;
          // ld_last on the final slot is a legal full image, not an overflow
          if (bus.ld_last) begin
            state_d = RUN;
            pc_init = 1'b1;
          end else if (wr_ptr_q == 32'(DEPTH_WORDS - 1)) begin
            state_d = HALT;
            fault_d = FLT_OVF;
          end
        end
      end
      RUN: begin
        instr_valid = ~sentinel;
        if (sentinel) begin
          state_d = HALT;
        end else begin
          step_en = 1'b1;
          if (misal) begin
            state_d = HALT;
            fault_d = FLT_MISAL;
          end else if (range_err) begin
            state_d = HALT;
            fault_d = FLT_RANGE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fault_q  <= FLT_NONE;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.imem_we     = imem_we;
  assign bus.imem_waddr  = wr_ptr_q << 2;
  assign bus.imem_wdata  = bus.ld_data;
  assign bus.imem_raddr  = pc;
  assign bus.pc          = pc;
  assign bus.instr       = bus.imem_rdata;
  assign bus.instr_valid = instr_valid;
  assign bus.halted      = (state_q == HALT);
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_imem_boot_fetch_ctrl.sv
// Directed bench for imem_boot_fetch_ctrl with a byte-array imem model.
module tb_imem_boot_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_mis;

  imem_boot_fetch_ctrl_if bus();

  imem_boot_fetch_ctrl #(
    .DEPTH_WORDS (32),
    .RESET_PC    (32'h0),
    .SENTINEL    (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 128-byte little-endian imem, combinational read
  logic [7:0] mem [0:127];

  always @(posedge clk) begin
    if (bus.imem_we && bus.imem_waddr < 32'd128) begin
      mem[int'(bus.imem_waddr[6:0])]     <= bus.imem_wdata[7:0];
      mem[int'(bus.imem_waddr[6:0]) + 1] <= bus.imem_wdata[15:8];
      mem[int'(bus.imem_waddr[6:0]) + 2] <= bus.imem_wdata[23:16];
      mem[int'(bus.imem_waddr[6:0]) + 3] <= bus.imem_wdata[31:24];
    end
  end

  always_comb begin
    bus.imem_rdata = 32'h0;
    if (bus.imem_raddr < 32'd125)
      bus.imem_rdata = {mem[int'(bus.imem_raddr[6:0]) + 3], mem[int'(bus.imem_raddr[6:0]) + 2],
                        mem[int'(bus.imem_raddr[6:0]) + 1], mem[int'(bus.imem_raddr[6:0])]};
  end

  typedef struct {
    logic        boot, run, vld, last;
    logic [31:0] data;
    logic        stall, redir;
    logic [31:0] rpc;
    logic        e_ready, e_we;
    logic [31:0] e_waddr;
    logic        cpc;
    logic [31:0] e_pc;
    logic        e_iv, e_h;
    logic [1:0]  e_f;
  } vec_t;

  vec_t vt [0:22];

  function automatic vec_t mk(input logic b, r, v, l, input logic [31:0] d,
                              input logic s, rd, input logic [31:0] rp,
                              input logic er, ew, input logic [31:0] ewa,
                              input logic cp, input logic [31:0] ep,
                              input logic eiv, eh, input logic [1:0] ef);
    vec_t x;
    x.boot = b; x.run = r; x.vld = v; x.last = l; x.data = d;
    x.stall = s; x.redir = rd; x.rpc = rp;
    x.e_ready = er; x.e_we = ew; x.e_waddr = ewa; x.cpc = cp; x.e_pc = ep;
    x.e_iv = eiv; x.e_h = eh; x.e_f = ef;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.boot_start  = x.boot;
    bus.run_start   = x.run;
    bus.ld_valid    = x.vld;
    bus.ld_last     = x.last;
    bus.ld_data     = x.data;
    bus.stall       = x.stall;
    bus.redirect    = x.redir;
    bus.redirect_pc = x.rpc;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 0,32'h0, 0,0,2'd0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    idle_inputs();

    //        b r v l data          s r rpc      rdy we waddr  cp pc      iv h f
    vt[0]  = mk(0,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h0,  0,0,2'd0);
    vt[1]  = mk(1,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h0,  0,0,2'd0);
    vt[2]  = mk(0,0,1,0,32'h00500093, 0,0,32'h0,  1,1,32'h0,  0,32'h0,  0,0,2'd0);
    vt[3]  = mk(0,0,0,0,32'h0,        0,0,32'h0,  1,0,32'h4,  0,32'h0,  0,0,2'd0);
    vt[4]  = mk(0,0,1,0,32'h00A00113, 0,0,32'h0,  1,1,32'h4,  0,32'h0,  0,0,2'd0);
    vt[5]  = mk(0,0,0,0,32'h0,        0,0,32'h0,  1,0,32'h8,  0,32'h0,  0,0,2'd0);
    vt[6]  = mk(0,0,1,1,32'hFFFFFFFF, 0,0,32'h0,  1,1,32'h8,  0,32'h0,  0,0,2'd0);
    vt[7]  = mk(0,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h0,  1,0,2'd0);
    vt[8]  = mk(0,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h4,  1,0,2'd0);
    vt[9]  = mk(0,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h8,  0,0,2'd0);
    vt[10] = mk(1,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h8,  0,1,2'd0);
    vt[11] = mk(0,0,1,0,32'h00000013, 0,0,32'h0,  1,1,32'h0,  0,32'h0,  0,0,2'd0);
    vt[12] = mk(0,0,1,0,32'h00000013, 0,0,32'h0,  1,1,32'h4,  0,32'h0,  0,0,2'd0);
    vt[13] = mk(0,0,1,1,32'h00000013, 0,0,32'h0,  1,1,32'h8,  0,32'h0,  0,0,2'd0);
    vt[14] = mk(0,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h0,  1,0,2'd0);
    vt[15] = mk(0,0,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h4,  1,0,2'd0);
    vt[16] = mk(0,0,0,0,32'h0,        1,1,32'h10, 0,0,32'h0,  1,32'h8,  1,0,2'd0);
    vt[17] = mk(0,0,0,0,32'h0,        0,1,32'h10, 0,0,32'h0,  1,32'h8,  1,0,2'd0);
    vt[18] = mk(0,0,0,0,32'h0,        0,1,32'h12, 0,0,32'h0,  1,32'h10, 1,0,2'd0);
    vt[19] = mk(0,1,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h10, 0,1,2'd2);
    vt[20] = mk(0,0,0,0,32'h0,        0,1,32'h80, 0,0,32'h0,  1,32'h0,  1,0,2'd0);
    vt[21] = mk(1,1,0,0,32'h0,        0,0,32'h0,  0,0,32'h0,  1,32'h0,  0,1,2'd3);
    vt[22] = mk(0,0,0,0,32'h0,        0,0,32'h0,  1,0,32'h0,  0,32'h0,  0,0,2'd0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d ld_ready", i), 32'(bus.ld_ready), 32'(vt[i].e_ready));
      chk($sformatf("v%0d imem_we", i), 32'(bus.imem_we), 32'(vt[i].e_we));
      if (vt[i].e_we) chk($sformatf("v%0d imem_waddr", i), bus.imem_waddr, vt[i].e_waddr);
      if (vt[i].cpc) chk($sformatf("v%0d pc", i), bus.pc, vt[i].e_pc);
      chk($sformatf("v%0d instr_valid", i), 32'(bus.instr_valid), 32'(vt[i].e_iv));
      chk($sformatf("v%0d halted", i), 32'(bus.halted), 32'(vt[i].e_h));
      chk($sformatf("v%0d fault", i), 32'(bus.fault), 32'(vt[i].e_f));
      next_cycle();
    end

    // Overflow: 32 words, none flagged last
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h100 + 32'(i);
      #1;
      chk($sformatf("ovf%0d imem_we", i), 32'(bus.imem_we), 32'd1);
      chk($sformatf("ovf%0d imem_waddr", i), bus.imem_waddr, 32'(i * 4));
      chk($sformatf("ovf%0d halted", i), 32'(bus.halted), 32'd0);
      next_cycle();
    end
    #1;
    chk("ovf ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("ovf imem_we", 32'(bus.imem_we), 32'd0);
    chk("ovf halted", 32'(bus.halted), 32'd1);
    chk("ovf fault", 32'(bus.fault), 32'd1);

    // Reset mid-LOAD, then run the partial image
    idle_inputs();
    bus.boot_start = 1'b1;
    next_cycle();
    bus.boot_start = 1'b0;
    bus.ld_valid   = 1'b1;
    bus.ld_data    = 32'h1111_1111;
    next_cycle();
    bus.ld_data    = 32'h2222_2222;
    next_cycle();
    bus.ld_data    = 32'h3333_3333;
    #1;
    chk("rst pre ld_ready", 32'(bus.ld_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst halted", 32'(bus.halted), 32'd0);
    chk("rst fault", 32'(bus.fault), 32'd0);
    chk("rst pc", bus.pc, 32'h0);
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    bus.run_start = 1'b1;
    next_cycle();
    bus.run_start = 1'b0;
    #1;
    chk("part pc0", bus.pc, 32'h0);
    chk("part instr0", bus.instr, 32'h1111_1111);
    chk("part iv0", 32'(bus.instr_valid), 32'd1);
    next_cycle();
    #1;
    chk("part pc4", bus.pc, 32'h4);
    chk("part instr4", bus.instr, 32'h2222_2222);
    next_cycle();
    bus.stall = 1'b1;
    #1;
    chk("part pc8", bus.pc, 32'h8);
    chk("part instr8", bus.instr, 32'h0000_0102);
    next_cycle();
    #1;
    chk("part stall pc", bus.pc, 32'h8);
    bus.stall = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
